shift_l_share_arb: RTL and testbench

//  Shares one left-shift datapath among NREQ requesters.
//  - Round-robin arbitration over valid/ready request channels.
//  - Computes z = sign/zero-extended a shifted left by s, truncated to WIDTH_Z.
//  - Result is held in a single output register stage with valid/ready handshake.
//  - Tagged with the winning requester index.
//  - Sits between HLS-generated requester blocks and their consumer, replacing NREQ shifter copies.

---
 rtl/shift_l_share_arb.sv | 125 ++++++++++++
 tb/tb_shift_l_share_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_l_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : shift_l_share_arb
//  Description : Round-robin shared left shifter. NREQ valid/ready requesters
//                share one sign/zero-extending shifter feeding a single
//                output register stage tagged with the winning index.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_l_share_arb #(
    parameter int NREQ    = 2,
    parameter int ID_W    = 1,
    parameter int WIDTH_A = 16,
    parameter int SIGND_A = 1,
    parameter int WIDTH_S = 4,
    parameter int WIDTH_Z = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_vld,
    output logic [NREQ-1:0]           req_rdy,
    input  logic [NREQ*WIDTH_A-1:0]   req_a,
    input  logic [NREQ*WIDTH_S-1:0]   req_s,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [WIDTH_Z-1:0]        rsp_z,
    output logic [ID_W-1:0]           rsp_id
);

    // Extension width keeps the sign bit above the operand even when WIDTH_Z is narrow.
    localparam int c_EXT_W = (WIDTH_A + 1 > WIDTH_Z) ? WIDTH_A + 1 : WIDTH_Z;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [WIDTH_Z-1:0]  r_z;

    logic                w_can_acc;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic                w_accept;
    logic [WIDTH_A-1:0]  w_req_a [NREQ];
    logic [WIDTH_S-1:0]  w_req_s [NREQ];
    logic [WIDTH_A-1:0]  w_sel_a;
    logic [WIDTH_S-1:0]  w_sel_s;
    logic [c_EXT_W-1:0]  w_ext;
    logic [c_EXT_W-1:0]  w_shl;
    logic [WIDTH_Z-1:0]  w_shl_z;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_a[gi] = req_a[gi*WIDTH_A +: WIDTH_A];
            assign w_req_s[gi] = req_s[gi*WIDTH_S +: WIDTH_S];
        end
    endgenerate

    assign w_can_acc = ~rst & ((r_state == ST_EMPTY) | rsp_rdy);

    // Rotating priority scan starting at the pointer.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_vld[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (w_can_acc && w_found) begin
            req_rdy[w_win] = 1'b1;
        end
    end

    assign w_accept  = |(req_rdy & req_vld);
    assign w_ptr_nxt = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;

    assign w_sel_a = w_req_a[w_win];
    assign w_sel_s = w_req_s[w_win];

    generate
        if (SIGND_A != 0) begin : g_sext
            assign w_ext = {{(c_EXT_W - WIDTH_A){w_sel_a[WIDTH_A-1]}}, w_sel_a};
        end else begin : g_zext
            assign w_ext = {{(c_EXT_W - WIDTH_A){1'b0}}, w_sel_a};
        end
    endgenerate

    // Shifting in the wider domain makes s >= WIDTH_Z naturally produce zero low bits.
    assign w_shl   = w_ext << w_sel_s;
    assign w_shl_z = w_shl[WIDTH_Z-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_z     <= '0;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_z     <= w_shl_z;
            r_id    <= w_win;
            r_ptr   <= w_ptr_nxt;
        end else if (r_state == ST_FULL && rsp_rdy) begin
            r_state <= ST_EMPTY;
        end
    end

    assign rsp_vld = (r_state == ST_FULL);
    assign rsp_z   = r_z;
    assign rsp_id  = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_l_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_l_share_arb
//  Description : Self-checking bench; signed and unsigned instances share
//                stimulus and are compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_l_share_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_vld;
    logic [31:0] req_a;
    logic [7:0]  req_s;
    logic        rsp_rdy;

    logic [1:0]  req_rdy,   req_rdy_u;
    logic        rsp_vld,   rsp_vld_u;
    logic [31:0] rsp_z,     rsp_z_u;
    logic [0:0]  rsp_id,    rsp_id_u;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_full = 1'b0;
    logic [31:0] m_z    = '0;
    logic [31:0] m_zu   = '0;
    int          m_id   = 0;
    int          m_ptr  = 0;

    shift_l_share_arb #(
        .NREQ(2), .ID_W(1), .WIDTH_A(16), .SIGND_A(1), .WIDTH_S(4), .WIDTH_Z(32)
    ) u_dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_s(req_s), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_z(rsp_z), .rsp_id(rsp_id)
    );

    shift_l_share_arb #(
        .NREQ(2), .ID_W(1), .WIDTH_A(16), .SIGND_A(0), .WIDTH_S(4), .WIDTH_Z(32)
    ) u_dut_u (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy_u),
        .req_a(req_a), .req_s(req_s), .rsp_vld(rsp_vld_u), .rsp_rdy(rsp_rdy),
        .rsp_z(rsp_z_u), .rsp_id(rsp_id_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplication by 2**s on the extended integer value, then modulo 2**32.
    function automatic logic [31:0] shl_model(input logic [15:0] a, input logic [3:0] s, input bit sgn);
        longint v;
        v = sgn ? longint'($signed(a)) : longint'({48'd0, a});
        v = v * (longint'(1) << s);
        return 32'(v);
    endfunction

    function automatic int grant(input logic [1:0] vld, input int ptr);
        for (int k = 0; k < 2; k++) begin
            if (vld[(ptr + k) % 2]) return (ptr + k) % 2;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [1:0] exp_rdy;
        logic [15:0] ga;
        logic [3:0]  gs;
        g = rst ? -1 : grant(req_vld, m_ptr);
        exp_rdy = 2'b00;
        if (g >= 0 && (!m_full || rsp_rdy)) exp_rdy[g] = 1'b1;
        check("req_rdy",   {62'd0, req_rdy},   {62'd0, exp_rdy});
        check("req_rdy_u", {62'd0, req_rdy_u}, {62'd0, exp_rdy});
        check("rsp_vld",   {63'd0, rsp_vld},   {63'd0, m_full});
        check("rsp_vld_u", {63'd0, rsp_vld_u}, {63'd0, m_full});
        if (m_full) begin
            check("rsp_z",    {32'd0, rsp_z},    {32'd0, m_z});
            check("rsp_z_u",  {32'd0, rsp_z_u},  {32'd0, m_zu});
            check("rsp_id",   {63'd0, rsp_id},   64'(m_id));
            check("rsp_id_u", {63'd0, rsp_id_u}, 64'(m_id));
        end
        if (rst) begin
            m_full = 1'b0; m_z = '0; m_zu = '0; m_id = 0; m_ptr = 0;
        end else if (exp_rdy != 2'b00) begin
            ga     = req_a[g*16 +: 16];
            gs     = req_s[g*4 +: 4];
            m_z    = shl_model(ga, gs, 1'b1);
            m_zu   = shl_model(ga, gs, 1'b0);
            m_id   = g;
            m_ptr  = (g + 1) % 2;
            m_full = 1'b1;
        end else if (m_full && rsp_rdy) begin
            m_full = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_vld = 2'b11; rsp_rdy = 1'b1;
        req_a = {16'h0002, 16'h0001}; req_s = 8'h00;

        // Model anchors
        check("model_sgn",   {32'd0, shl_model(16'h8001, 4'd4, 1'b1)}, 64'hFFF8_0010);
        check("model_unsgn", {32'd0, shl_model(16'h8001, 4'd4, 1'b0)}, 64'h0008_0010);
        check("model_s15",   {32'd0, shl_model(16'h0001, 4'd15, 1'b1)}, 64'h0000_8000);

        // Reset held two cycles with every requester valid
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_rdy", {62'd0, req_rdy | req_rdy_u}, 64'd0);
            check("rst_vld", {63'd0, rsp_vld | rsp_vld_u}, 64'd0);
            check("rst_z",   {32'd0, rsp_z | rsp_z_u},     64'd0);
        end
        rst = 1'b0;
        #1;
        check("rr_first_rdy", {62'd0, req_rdy}, 64'b01);

        // Round-robin under continuous demand
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_vld", {63'd0, rsp_vld}, 64'd1);
            check("rr_id",  {63'd0, rsp_id},  64'(k % 2));
            if (k == 3) begin
                req_vld = 2'b01; req_a[15:0] = 16'h8001; req_s[3:0] = 4'd4;
            end
        end

        tick();
        check("sext_z",  {32'd0, rsp_z},   64'hFFF8_0010);
        check("zext_z",  {32'd0, rsp_z_u}, 64'h0008_0010);
        check("sext_id", {63'd0, rsp_id},  64'd0);

        req_a[15:0] = 16'h0001; req_s[3:0] = 4'd15;
        tick();
        check("s15_z",   {32'd0, rsp_z},   64'h0000_8000);
        check("s15_z_u", {32'd0, rsp_z_u}, 64'h0000_8000);

        // Backpressure: output frozen, no grants
        rsp_rdy = 1'b0; req_vld = 2'b11;
        req_a = {16'h0005, 16'h0003}; req_s = {4'd2, 4'd1};
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_vld", {63'd0, rsp_vld}, 64'd1);
            check("bp_z",   {32'd0, rsp_z},   64'h0000_8000);
            check("bp_id",  {63'd0, rsp_id},  64'd0);
            check("bp_rdy", {62'd0, req_rdy}, 64'd0);
        end
        rsp_rdy = 1'b1;
        #1;
        check("bp_release_rdy", {62'd0, req_rdy}, 64'b10);
        tick();
        check("bp_nobubble_vld", {63'd0, rsp_vld}, 64'd1);
        check("bp_nobubble_id",  {63'd0, rsp_id},  64'd1);
        check("bp_nobubble_z",   {32'd0, rsp_z},   64'd20);

        // Reset while FULL drops the result and rewinds the pointer
        rst = 1'b1;
        tick();
        check("rstfull_vld", {63'd0, rsp_vld}, 64'd0);
        rst = 1'b0;
        #1;
        check("rstfull_rdy", {62'd0, req_rdy}, 64'b01);
        tick();
        check("rstfull_id", {63'd0, rsp_id}, 64'd0);
        check("rstfull_z",  {32'd0, rsp_z},  64'd6);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 99) == 0);
            req_vld = 2'($urandom);
            req_a   = $urandom;
            req_s   = 8'($urandom);
            rsp_rdy = ($urandom_range(0, 9) < 7);
            tick();
        end

        rst = 1'b0; req_vld = 2'b00; rsp_rdy = 1'b1;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
